// File: rtl/instr_fetch_master_if.sv
// rtl/instr_fetch_master_if.sv - req/gnt/rvalid instruction memory bus bundle
interface instr_fetch_master_if;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, addr, input gnt, rvalid, rdata, err);
  modport slave  (input req, addr, output gnt, rvalid, rdata, err);
endinterface

// File: rtl/instr_fetch_master.sv
// rtl/instr_fetch_master.sv - pipelined instruction fetch initiator with response FIFO
// Stale responses after a redirect are dropped by a discard counter instead of tagging.
module instr_fetch_master #(
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] BOOT_ADDR       = 32'h0000_0080
) (
  input  logic        clk,
  input  logic        rst,
  instr_fetch_master_if.master bus,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rdata,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic        busy
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int NW = $clog2(MAX_OUTSTANDING + 1);

  typedef enum logic {FETCH, HALT} mode_t;

  mode_t          mode;
  logic [31:0]    fetch_addr;
  logic [31:0]    resp_addr;
  logic           held;
  logic           held_stale;
  logic [31:0]    held_addr;
  logic [NW-1:0]  n_cnt;
  logic [NW-1:0]  d_cnt;
  logic [CW-1:0]  c_cnt;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic [64:0]    fifo_mem [FIFO_DEPTH];

  logic           start;
  logic           accept;
  logic           resp;
  logic           drop;
  logic           push;
  logic           pop;
  logic           stale_acc;
  logic [NW-1:0]  n_next;
  logic [31:0]    target;
  logic           unused_branch_lsbs;

  assign target             = {branch_addr[31:2], 2'b00};
  assign unused_branch_lsbs = ^branch_addr[1:0];

  // Credit covers both in-flight words and buffered words so a push never finds the FIFO full.
  assign start = !held && (mode == FETCH) && !branch
               && (int'(n_cnt) < MAX_OUTSTANDING)
               && (int'(n_cnt) + int'(c_cnt) < FIFO_DEPTH);

  assign bus.req  = !rst && (held || start);
  assign bus.addr = held ? held_addr : fetch_addr;

  assign accept    = bus.req && bus.gnt;
  assign resp      = bus.rvalid && (n_cnt != '0);
  assign drop      = resp && (d_cnt != '0);
  assign push      = resp && (d_cnt == '0) && !branch;
  assign pop       = out_ready && (c_cnt != '0) && !branch;
  assign stale_acc = accept && held && held_stale;
  assign n_next    = n_cnt + NW'(accept) - NW'(resp);

  assign out_valid = (c_cnt != '0);
  assign {out_err, out_addr, out_rdata} = out_valid ? fifo_mem[rd_ptr] : 65'd0;
  assign busy      = (n_cnt != '0) || (d_cnt != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {bus.err, resp_addr, bus.rdata};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode       <= FETCH;
      fetch_addr <= BOOT_ADDR;
      resp_addr  <= BOOT_ADDR;
      held       <= 1'b0;
      held_stale <= 1'b0;
      held_addr  <= BOOT_ADDR;
      n_cnt      <= '0;
      d_cnt      <= '0;
      c_cnt      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
    end else begin
      assert (!(push && (c_cnt == CW'(FIFO_DEPTH))));

      n_cnt <= n_next;
      if (branch) begin
        d_cnt <= n_next;
      end else begin
        d_cnt <= d_cnt + NW'(stale_acc) - NW'(drop);
      end

      if (bus.req && !bus.gnt) begin
        held      <= 1'b1;
        held_addr <= bus.addr;
      end else if (accept) begin
        held <= 1'b0;
      end

      // A held request that outlives a redirect belongs to the old stream.
      if (accept) begin
        held_stale <= 1'b0;
      end else if (branch && held) begin
        held_stale <= 1'b1;
      end

      if (branch) begin
        fetch_addr <= target;
      end else if (accept && !(held && held_stale)) begin
        fetch_addr <= fetch_addr + 32'd4;
      end

      if (branch) begin
        resp_addr <= target;
      end else if (push) begin
        resp_addr <= resp_addr + 32'd4;
      end

      if (branch) begin
        mode <= FETCH;
      end else if (push && bus.err) begin
        mode <= HALT;
      end

      if (branch) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        c_cnt  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        c_cnt <= c_cnt + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_master.sv
// tb/tb_instr_fetch_master.sv - directed bench with memory model and output scoreboard
module tb_instr_fetch_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [31:0] branch_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_rdata;
  logic [31:0] out_addr;
  logic        out_err;
  logic        busy;

  instr_fetch_master_if bus ();

  instr_fetch_master dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .branch      (branch),
    .branch_addr (branch_addr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_rdata   (out_rdata),
    .out_addr    (out_addr),
    .out_err     (out_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        sb [$];
  exp_t        mon_e;
  logic [31:0] mem_addr_q [$];
  int          mem_due_q [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          lat = 1;
  bit          gnt_en = 1'b0;
  bit          const_data = 1'b0;
  bit          mon_en = 1'b0;
  logic [31:0] err_addr = 32'h1;

  function automatic logic [31:0] memdat(input logic [31:0] a);
    return const_data ? 32'h0000_0013 : (a ^ 32'hA5A5_5A5A);
  endfunction

  assign bus.gnt = gnt_en & bus.req;

  // Memory model: records accepts, returns data in order after lat cycles.
  always @(posedge clk) begin
    if (bus.req && bus.gnt) begin
      mem_addr_q.push_back(bus.addr);
      mem_due_q.push_back(cyc + lat);
      acc_cnt++;
    end
    cyc++;
    #1;
    if (mem_due_q.size() > 0 && mem_due_q[0] <= cyc) begin
      bus.rvalid = 1'b1;
      bus.rdata  = memdat(mem_addr_q[0]);
      bus.err    = (mem_addr_q[0] == err_addr);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;
      bus.err    = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%h expected=none", out_addr);
      end
      if (sb.size() > 0) begin
        mon_e = sb.pop_front();
        chk("out_addr", out_addr, mon_e.addr);
        chk("out_rdata", out_rdata, mon_e.data);
        chk("out_err", {31'd0, out_err}, {31'd0, mon_e.err});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic expect_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      sb.push_back('{base + 32'(4 * i), memdat(base + 32'(4 * i)), base + 32'(4 * i) == err_addr});
    end
  endtask

  task automatic drain(input int maxc, input string tag);
    for (int i = 0; i < maxc && sb.size() > 0; i++) sample();
    chk(tag, 32'(sb.size()), 32'd0);
    sb.delete();
    tick();
    out_ready = 1'b0;
    mon_en    = 1'b0;
  endtask

  task automatic apply_reset(input bit clr);
    tick();
    rst       = 1'b1;
    branch    = 1'b0;
    gnt_en    = 1'b0;
    out_ready = 1'b0;
    mon_en    = 1'b0;
    @(negedge clk);
    if (clr) begin
      mem_addr_q.delete();
      mem_due_q.delete();
    end
    acc_cnt = 0;
    sb.delete();
    tick();
  endtask

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog simulation time limit reached");
  end

  initial begin
    rst = 1'b1; branch = 1'b0; branch_addr = 32'h0; out_ready = 1'b0;

    // Reset values
    apply_reset(1'b1);
    sample();
    chk("rst_req", {31'd0, bus.req}, 32'd0);
    chk("rst_addr", bus.addr, 32'h80);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_rdata", out_rdata, 32'd0);
    chk("rst_out_addr", out_addr, 32'd0);
    chk("rst_out_err", {31'd0, out_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick();

    // Sequential streaming, zero-wait memory
    lat = 1; gnt_en = 1'b1; const_data = 1'b1; out_ready = 1'b1; mon_en = 1'b1;
    expect_words(32'h80, 8);
    rst = 1'b0;
    sample();
    chk("stream_req", {31'd0, bus.req}, 32'd1);
    chk("stream_addr", bus.addr, 32'h80);
    tick();
    sample();
    chk("stream_lat_c1", {31'd0, out_valid}, 32'd0);
    tick();
    sample();
    chk("stream_lat_c2", {31'd0, out_valid}, 32'd1);
    begin
      int gaps = 0;
      repeat (7) begin
        sample();
        if (!out_valid) gaps++;
      end
      chk("stream_gaps", 32'(gaps), 32'd0);
    end
    drain(20, "stream_drain");
    const_data = 1'b0;

    // Backpressure
    apply_reset(1'b1);
    lat = 1; gnt_en = 1'b1;
    rst = 1'b0;
    repeat (20) tick();
    sample();
    chk("bp_accepts", 32'(acc_cnt), 32'd4);
    chk("bp_req", {31'd0, bus.req}, 32'd0);
    chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_out_addr", out_addr, 32'h80);
    tick();
    expect_words(32'h80, 8);
    out_ready = 1'b1; mon_en = 1'b1;
    drain(40, "bp_drain");

    // Branch with two responses in flight
    apply_reset(1'b1);
    lat = 3; gnt_en = 1'b1; out_ready = 1'b1; mon_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    branch = 1'b1; branch_addr = 32'h1002;
    expect_words(32'h1000, 3);
    sample();
    chk("br_req_low", {31'd0, bus.req}, 32'd0);
    chk("br_busy", {31'd0, busy}, 32'd1);
    tick();
    branch = 1'b0;
    drain(60, "br_drain");
    repeat (20) tick();
    sample();
    chk("br_busy_idle", {31'd0, busy}, 32'd0);
    chk("br_req_full", {31'd0, bus.req}, 32'd0);

    // Held request across branch
    apply_reset(1'b1);
    lat = 1; gnt_en = 1'b1;
    rst = 1'b0;
    tick();
    tick();
    gnt_en = 1'b0;
    sample();
    chk("held_req", {31'd0, bus.req}, 32'd1);
    chk("held_addr", bus.addr, 32'h88);
    tick();
    branch = 1'b1; branch_addr = 32'h200;
    sample();
    chk("held_br_req", {31'd0, bus.req}, 32'd1);
    chk("held_br_addr", bus.addr, 32'h88);
    tick();
    branch = 1'b0;
    expect_words(32'h200, 3);
    out_ready = 1'b1; mon_en = 1'b1;
    sample();
    chk("held_after_addr", bus.addr, 32'h88);
    tick();
    gnt_en = 1'b1;
    sample();
    chk("held_gnt_addr", bus.addr, 32'h88);
    tick();
    sample();
    chk("held_next_req", {31'd0, bus.req}, 32'd1);
    chk("held_next_addr", bus.addr, 32'h200);
    drain(40, "held_drain");

    // Error halt then branch restart
    apply_reset(1'b1);
    lat = 1; gnt_en = 1'b1; err_addr = 32'h84; out_ready = 1'b1; mon_en = 1'b1;
    expect_words(32'h80, 3);
    rst = 1'b0;
    drain(30, "halt_drain");
    repeat (5) tick();
    sample();
    chk("halt_req", {31'd0, bus.req}, 32'd0);
    chk("halt_accepts", 32'(acc_cnt), 32'd3);
    tick();
    branch = 1'b1; branch_addr = 32'h300;
    tick();
    branch = 1'b0;
    expect_words(32'h300, 2);
    out_ready = 1'b1; mon_en = 1'b1;
    sample();
    chk("restart_req", {31'd0, bus.req}, 32'd1);
    chk("restart_addr", bus.addr, 32'h300);
    chk("restart_t1_valid", {31'd0, out_valid}, 32'd0);
    tick();
    sample();
    chk("restart_t2_valid", {31'd0, out_valid}, 32'd0);
    tick();
    sample();
    chk("restart_t3_valid", {31'd0, out_valid}, 32'd1);
    drain(20, "restart_drain");
    err_addr = 32'h1;

    // Reset mid-burst with N = 2, C = 2, late responses after release
    apply_reset(1'b1);
    lat = 3; gnt_en = 1'b1;
    rst = 1'b0;
    repeat (6) tick();
    rst = 1'b1; gnt_en = 1'b0;
    sample();
    chk("mid_rst_req", {31'd0, bus.req}, 32'd0);
    chk("mid_rst_addr", bus.addr, 32'h80);
    chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_out_addr", out_addr, 32'd0);
    chk("mid_rst_out_rdata", out_rdata, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    sample();
    chk("late_valid", {31'd0, out_valid}, 32'd0);
    chk("late_busy", {31'd0, busy}, 32'd0);
    chk("late_req", {31'd0, bus.req}, 32'd1);
    chk("late_addr", bus.addr, 32'h80);
    tick();
    expect_words(32'h80, 3);
    gnt_en = 1'b1; out_ready = 1'b1; mon_en = 1'b1;
    drain(40, "late_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
